// File: rtl/err_priority_arb.sv
// err_priority_arb: latches NUM_ERR error sources into sticky pending bits
// and reports them one at a time over a valid/ready handshake. A runtime
// priority table maps each priority slot (0 = highest) to an error index.
// Optional feature macro: ERR_PRIO_OVF_EN adds the saturating ovf_cnt output.
module err_priority_arb #(
  parameter int  NUM_ERR = 32,
  parameter int  CNT_W   = 8,
  localparam int IDX_W   = $clog2(NUM_ERR)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_ERR-1:0]       err_in,
  input  logic                     cfg_we,
  input  logic [NUM_ERR*IDX_W-1:0] cfg_in,
  input  logic                     clr_all,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic [NUM_ERR-1:0]       out_onehot,
  output logic [NUM_ERR-1:0]       pending
`ifdef ERR_PRIO_OVF_EN
  ,
  output logic [CNT_W-1:0]         ovf_cnt
`endif
);

  // Index space addressable by a table entry; indices at or above NUM_ERR
  // map onto zero bits of the extended pending vector and so never win.
  localparam int EXT_W = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    RPT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_ERR-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_ERR-1:0]   onehot_q, onehot_d;
  logic [IDX_W-1:0]     table_q [NUM_ERR];
  logic [IDX_W-1:0]     cfg_slot [NUM_ERR];

  logic [EXT_W-1:0]     pend_ext;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [NUM_ERR-1:0]   win_onehot;
  logic                 handshake;
  logic [NUM_ERR-1:0]   clr_mask;

  // Unpack the flattened configuration bus into one entry per slot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ERR; gi++) begin : g_cfg_slot
      assign cfg_slot[gi] = cfg_in[gi*IDX_W +: IDX_W];
    end
  endgenerate

  assign pend_ext   = EXT_W'(pending_q);
  assign out_valid  = (state_q == RPT);
  assign handshake  = out_valid & out_ready;
  assign clr_mask   = handshake ? onehot_q : '0;
  assign win_onehot = {{(NUM_ERR-1){1'b0}}, 1'b1} << win_idx;

  // Winner search: scan from the lowest-priority slot upward so the lowest
  // matching slot is the last to assign; duplicates in later slots lose.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int p = NUM_ERR - 1; p >= 0; p--) begin
      if (pend_ext[table_q[p]]) begin
        win_found = 1'b1;
        win_idx   = table_q[p];
      end
    end
  end

  // Sticky pending update: accepted report clears its bit, new errors win.
  always_comb begin
    if (clr_all) begin
      pending_d = err_in;
    end else begin
      pending_d = (pending_q & ~clr_mask) | err_in;
    end
  end

  // Report sequencer next-state and report register loading.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = SEL;
        end
      end
      SEL: begin
        if (win_found) begin
          idx_d    = win_idx;
          onehot_d = win_onehot;
          state_d  = RPT;
        end else begin
          state_d = IDLE;
        end
      end
      RPT: begin
        if (out_ready) begin
          onehot_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        onehot_d = '0;
        state_d  = IDLE;
      end
    endcase
    if (clr_all) begin
      onehot_d = '0;
      state_d  = IDLE;
    end
  end

  // State, pending, report and priority-table registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      onehot_q  <= '0;
      for (int p = 0; p < NUM_ERR; p++) begin
        table_q[p] <= IDX_W'(p);
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
      if (cfg_we) begin
        for (int p = 0; p < NUM_ERR; p++) begin
          table_q[p] <= cfg_slot[p];
        end
      end
    end
  end

  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign pending    = pending_q;

`ifdef ERR_PRIO_OVF_EN
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             ovf_hit;

  // An error re-fired while still pending (and not being retired) is lost.
  assign ovf_hit = |(err_in & pending_q & ~clr_mask);

  // Saturating count of lost error events.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_all) begin
      ovf_d = '0;
    end else if (ovf_hit && !(&ovf_q)) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  // Overflow counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_cnt = ovf_q;
`endif

endmodule

// File: tb/tb_err_priority_arb.sv
// Testbench for err_priority_arb (NUM_ERR=32): directed scenarios plus a
// randomized run checked against a behavioural reference model.
module tb_err_priority_arb;

  localparam int N = 32;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   err_in = '0;
  logic           cfg_we = 1'b0;
  logic [N*W-1:0] cfg_in = '0;
  logic           clr_all = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_idx;
  logic [N-1:0]   out_onehot;
  logic [N-1:0]   pending;
`ifdef ERR_PRIO_OVF_EN
  logic [7:0]     ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Indices accepted by the consumer, in order.
  int acc_q[$];

  // Reference model state.
  logic [N-1:0] m_pend;
  bit           m_valid;
  bit           m_sel;
  int           m_idx;
  int           m_tab[N];
  int           m_ovf;

  err_priority_arb #(.NUM_ERR(N), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .err_in     (err_in),
    .cfg_we     (cfg_we),
    .cfg_in     (cfg_in),
    .clr_all    (clr_all),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .pending    (pending)
`ifdef ERR_PRIO_OVF_EN
    ,
    .ovf_cnt    (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Highest-priority pending error named by the table, or -1.
  function automatic int m_winner();
    for (int p = 0; p < N; p++) begin
      if (m_tab[p] < N && m_pend[m_tab[p]]) return m_tab[p];
    end
    return -1;
  endfunction

  function automatic void m_reset();
    m_pend  = '0;
    m_valid = 0;
    m_sel   = 0;
    m_idx   = 0;
    m_ovf   = 0;
    for (int p = 0; p < N; p++) m_tab[p] = p;
  endfunction

  // Advance the model by one clock using the inputs present before the edge.
  function automatic void m_step(logic [N-1:0] e, bit rdy, bit clr, bit we);
    logic [N-1:0] mask;
    bit hs;
    int w;
    bit nv;
    bit ns;
    mask = '0;
    hs   = m_valid && rdy;
    if (hs) mask[m_idx] = 1'b1;
    w  = m_winner();
    nv = m_valid;
    ns = m_sel;
    if (clr) begin
      if ((e & m_pend & ~mask) != 0 && 0 == 1) m_ovf = m_ovf;
      m_ovf = 0;
      m_pend = e;
      nv = 0;
      ns = 0;
    end else begin
      if ((e & m_pend & ~mask) != 0 && m_ovf < 255) m_ovf++;
      m_pend = (m_pend & ~mask) | e;
      if (m_valid) begin
        if (hs) nv = 0;
      end else if (m_sel) begin
        if (w >= 0) begin
          nv = 1;
          m_idx = w;
        end
        ns = 0;
      end else if (w >= 0) begin
        ns = 1;
      end
    end
    m_valid = nv;
    m_sel   = ns;
    if (we) begin
      for (int p = 0; p < N; p++) m_tab[p] = int'(cfg_in[p*W +: W]);
    end
  endfunction

  // One clock of stimulus; outputs are stable again when this returns.
  task automatic tick(input logic [N-1:0] e, input bit rdy, input bit clr, input bit we);
    err_in    = e;
    out_ready = rdy;
    clr_all   = clr;
    cfg_we    = we;
    if (out_valid && rdy && !rst) acc_q.push_back(int'(out_idx));
    if (!rst) m_step(e, rdy, clr, we);
    @(posedge clk);
    #1;
    err_in    = '0;
    out_ready = 1'b0;
    clr_all   = 1'b0;
    cfg_we    = 1'b0;
  endtask

  task automatic do_reset(input logic [N-1:0] e);
    rst = 1'b1;
    tick(e, 1'b0, 1'b0, 1'b0);
    tick(e, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    m_reset();
    acc_q.delete();
  endtask

  task automatic load_table(input int tab[N]);
    for (int p = 0; p < N; p++) cfg_in[p*W +: W] = W'(tab[p]);
    tick('0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        ok = 1;
        break;
      end
      tick('0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic run_reports(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (acc_q.size() >= n) begin
        ok = 1;
        break;
      end
      tick('0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset(32'hFFFF_FFFF);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (out_idx !== '0) begin errors++; $display("FAIL reset_idx got %0d want 0", out_idx); end
    if (out_onehot !== '0) begin errors++; $display("FAIL reset_onehot got %h want 0", out_onehot); end
    if (pending !== '0) begin errors++; $display("FAIL reset_pending got %h want 0", pending); end
    $display("reset: valid=%b idx=%0d pending=%h", out_valid, out_idx, pending);
  endtask

  task automatic test_identity();
    int exp_v[7] = '{0, 0, 1, 0, 0, 1, 0};
    int exp_i[7] = '{0, 0, 2, 0, 0, 6, 0};
    do_reset('0);
    tick(32'h0000_0044, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (out_valid !== exp_v[c][0]) begin
        errors++; $display("FAIL ident_valid cyc %0d got %b want %0d", c, out_valid, exp_v[c]);
      end
      if (exp_v[c] == 1) begin
        checks += 2;
        if (out_idx !== W'(exp_i[c])) begin errors++; $display("FAIL ident_idx got %0d want %0d", out_idx, exp_i[c]); end
        if (out_onehot !== (N'(1) << exp_i[c])) begin errors++; $display("FAIL ident_onehot got %h want bit %0d", out_onehot, exp_i[c]); end
        $display("identity: report idx=%0d at cycle %0d", out_idx, c);
      end
      if (c < 6) tick('0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (pending !== '0) begin errors++; $display("FAIL ident_pending got %h want 0", pending); end
  endtask

  task automatic test_reverse();
    int tab[N];
    int exp_o[10] = '{31, 30, 24, 23, 19, 18, 17, 16, 6, 2};
    bit ok;
    do_reset('0);
    for (int p = 0; p < N; p++) tab[p] = N - 1 - p;
    load_table(tab);
    tick(32'hC18F_0044, 1'b1, 1'b0, 1'b0);
    run_reports(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reverse_timeout got %0d reports want 10", acc_q.size()); end
    for (int i = 0; i < 10 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] != exp_o[i]) begin errors++; $display("FAIL reverse_order[%0d] got %0d want %0d", i, acc_q[i], exp_o[i]); end
      $display("reverse: report %0d idx=%0d", i, acc_q[i]);
    end
    tick('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pending !== '0) begin errors++; $display("FAIL reverse_pending got %h want 0", pending); end
  endtask

  task automatic test_stall();
    int tab[N];
    int exp_o[3] = '{31, 29, 1};
    bit ok;
    do_reset('0);
    for (int p = 0; p < N; p++) tab[p] = p;
    tab[0] = 31; tab[1] = 29; tab[2] = 1; tab[29] = 2; tab[31] = 0;
    load_table(tab);
    tick(32'hA000_0002, 1'b0, 1'b0, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_wait got valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      tick('0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== W'(31)) begin
        errors++; $display("FAIL stall_hold got valid=%b idx=%0d want 1/31", out_valid, out_idx);
      end
    end
    run_reports(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout got %0d reports want 3", acc_q.size()); end
    for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] != exp_o[i]) begin errors++; $display("FAIL stall_order[%0d] got %0d want %0d", i, acc_q[i], exp_o[i]); end
      $display("stall: report %0d idx=%0d", i, acc_q[i]);
    end
  endtask

  task automatic test_set_wins();
    bit ok;
    do_reset('0);
    tick(32'h20, 1'b0, 1'b0, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || out_idx !== W'(5)) begin errors++; $display("FAIL setwins_first got valid=%b idx=%0d want 1/5", out_valid, out_idx); end
    tick(32'h20, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (pending[5] !== 1'b1) begin errors++; $display("FAIL setwins_pending got %b want 1", pending[5]); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL setwins_drop got %b want 0", out_valid); end
    run_reports(2, ok);
    checks += 2;
    if (!ok || acc_q[1] != 5) begin errors++; $display("FAIL setwins_rereport got %0d reports want 2 of idx 5", acc_q.size()); end
    tick('0, 1'b0, 1'b0, 1'b0);
    if (pending !== '0) begin errors++; $display("FAIL setwins_final got %h want 0", pending); end
    $display("set_wins: reports=%0d pending=%h", acc_q.size(), pending);
  endtask

  task automatic test_clr_all();
    int tab[N];
    int exp_o[2] = '{2, 6};
    bit ok;
    do_reset('0);
    tick(32'h0000_00F0, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_00F0, 1'b0, 1'b0, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clr_wait got valid=%b want 1", out_valid); end
    tick('0, 1'b0, 1'b1, 1'b0);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b want 0", out_valid); end
    if (pending !== '0) begin errors++; $display("FAIL clr_pending got %h want 0", pending); end
    if (out_onehot !== '0) begin errors++; $display("FAIL clr_onehot got %h want 0", out_onehot); end
`ifdef ERR_PRIO_OVF_EN
    checks++;
    if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL clr_ovf got %0d want 0", ovf_cnt); end
`endif
    tick(32'h0000_0001, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_0100, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pending !== 32'h0000_0100) begin errors++; $display("FAIL clr_survive got %h want 00000100", pending); end
    $display("clr_all: pending=%h valid=%b", pending, out_valid);
    // Reset in the middle of a report also restores the identity table.
    for (int p = 0; p < N; p++) tab[p] = N - 1 - p;
    load_table(tab);
    tick(32'h0000_0044, 1'b0, 1'b0, 1'b0);
    wait_valid(ok);
    do_reset('0);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    if (pending !== '0) begin errors++; $display("FAIL rst_mid_pending got %h want 0", pending); end
    tick(32'h0000_0044, 1'b1, 1'b0, 1'b0);
    run_reports(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_timeout got %0d reports want 2", acc_q.size()); end
    for (int i = 0; i < 2 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] != exp_o[i]) begin errors++; $display("FAIL rst_mid_order[%0d] got %0d want %0d", i, acc_q[i], exp_o[i]); end
    end
    $display("rst_mid: reports after reset=%0d", acc_q.size());
  endtask

  task automatic test_random();
    int tab[N];
    logic [N-1:0] e;
    logic [N-1:0] exp_oh;
    bit rdy, clr, we;
    int bad;
    do_reset('0);
    bad = errors;
    for (int c = 0; c < 1500; c++) begin
      e   = ($urandom_range(0, 3) == 0) ? ($urandom() & $urandom() & $urandom()) : '0;
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 63) == 0);
      we  = ($urandom_range(0, 49) == 0);
      if (we) begin
        for (int p = 0; p < N; p++) cfg_in[p*W +: W] = W'($urandom_range(0, N - 1));
      end
      tick(e, rdy, clr, we);
      exp_oh = m_valid ? (N'(1) << m_idx) : '0;
      checks += 3;
      if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", c, out_valid, m_valid); end
      if (out_onehot !== exp_oh) begin errors++; $display("FAIL rand_onehot cyc %0d got %h want %h", c, out_onehot, exp_oh); end
      if (pending !== m_pend) begin errors++; $display("FAIL rand_pending cyc %0d got %h want %h", c, pending, m_pend); end
      if (m_valid) begin
        checks++;
        if (out_idx !== W'(m_idx)) begin errors++; $display("FAIL rand_idx cyc %0d got %0d want %0d", c, out_idx, m_idx); end
      end
`ifdef ERR_PRIO_OVF_EN
      checks++;
      if (ovf_cnt !== 8'(m_ovf)) begin errors++; $display("FAIL rand_ovf cyc %0d got %0d want %0d", c, ovf_cnt, m_ovf); end
`endif
    end
    $display("random: 1500 cycles, reports=%0d, new errors=%0d", acc_q.size(), errors - bad);
  endtask

`ifdef ERR_PRIO_OVF_EN
  task automatic test_ovf();
    do_reset('0);
    for (int c = 0; c < 300; c++) tick(32'h8, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL ovf_saturate got %0d want 255", ovf_cnt); end
    $display("ovf: ovf_cnt=%0d", ovf_cnt);
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_identity();
    test_reverse();
    test_stall();
    test_set_wins();
    test_clr_all();
    test_random();
`ifdef ERR_PRIO_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
